dot_acc_mx: RTL and testbench
=============================

# dot_acc_mx

Block accumulator stage that sits directly downstream of the integer dot-product unit. It consumes one k-element partial dot product per accepted beat and sums `n_beats` consecutive beats into one MX block result. It attaches the block's combined shared exponent, taken from the two E8M0 scales, and presents the result on a single-entry registered valid/ready output.

## Interface
- `bit_width`, 8: element width of the upstream operands.
- `k`, 4: elements per upstream dot product.
- `n_beats`, 8: partial products per MX block. Block size is `k*n_beats`. Must be ≥ 1.
- `in_width`, `2*bit_width + $clog2(k)`: width of the upstream dot product.
- `acc_width`, `in_width + $clog2(n_beats)`: accumulator and result width. For `n_beats` = 1, `acc_width` = `in_width`.

Ports:
- `i_clk`  in  1  clock. The block uses one clock, and all state is on its rising edge.
- `i_rst_n`  in  1  reset. Asynchronous assert, active-low.
- `i_dp`  in  `in_width`  signed two's-complement partial dot product.
- `i_scale_a`  in  8  E8M0 shared scale of operand A. Sampled on the first beat of a block.
- `i_scale_b`  in  8  E8M0 shared scale of operand B. Sampled on the first beat of a block.
- `i_valid`  in  1  `i_dp` is valid.
- `o_ready`  out  1  the block accepts `i_dp` this cycle.
- `o_valid`  out  1  the block result is valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_acc`  out  `acc_width`  signed block sum.
- `o_exp`  out  10  signed combined exponent: `scale_a + scale_b - 254`.
- `o_nan`  out  1  the block is NaN because either scale equals 0xFF.

## Operation
- A beat is accepted when `i_valid && o_ready`.
- `o_ready = !o_valid || i_ready`. This is a combinational path from `i_ready`. Every beat stalls while an unconsumed result is held.
- Beat counter `cnt`, range 0..`n_beats-1`, and accumulator `acc`, width `acc_width`, both reset to 0.
- Accepted beat with `cnt == 0`:
  - `acc <= sext(i_dp)`.
  - Latch `scale_a` and `scale_b`.
- Accepted beat with 0 < `cnt` < `n_beats-1`: `acc <= acc + sext(i_dp)`.
- Accepted beat with `cnt == n_beats-1`, the last beat:
  - Load the output register: `o_acc <= acc + sext(i_dp)`.
  - `o_exp <= {2'b0,sa} + {2'b0,sb} - 254`, computed as 10-bit signed.
  - `o_nan <= (sa==8'hFF) || (sb==8'hFF)`. The latched scales are used, except when `n_beats==1`, where the current-beat scales are used.
  - `o_valid <= 1`, `cnt <= 0`.
- Scales are sampled on beat 0 only. Scale inputs on later beats of the block are ignored.
- Width rule: sums are exact for full-range inputs. The accumulator does not overflow and does not saturate.
- `o_nan` does not gate `o_acc`. The sum is still produced.
- Output register:
  - `o_valid` clears on `i_ready` unless a new last beat is accepted in the same cycle. In that case it stays 1 with the new data.
  - While `o_valid && !i_ready`: `o_acc`, `o_exp` and `o_nan` are held stable.
- No input beat is ever dropped. A beat not accepted does not change state.

## Timing
- Reset values:
  - `o_valid` = 0, `o_acc` = 0, `o_exp` = 0, `o_nan` = 0.
  - `cnt` = 0, `acc` = 0, latched scales = 0.
  - `o_ready` = 1 while in reset, because `o_valid` = 0.
- Reset asserted mid-block discards the partial block and any held output immediately. The first beat accepted after release is beat 0.
- Latency: `o_valid` rises on the clock edge that accepts the last beat. The result is visible one cycle after the last beat's acceptance cycle.
- Throughput: one beat per cycle with `i_ready` held high. Back-to-back blocks run with no bubble. `o_valid` pulses for one cycle per block.
- Simultaneous output drain and last-beat accept: new data replaces old in the same edge.

## Test plan
- Sum and neutral exponent (defaults), `i_ready` = 1: 8 beats of `i_dp` = 100, scales 127/127 → one `o_valid` pulse, `o_acc` = 800, `o_exp` = 0, `o_nan` = 0.
- Extremes, `i_ready` = 1:
  - Block 1: 8 beats of +65536, scales 0/0 → `o_acc` = 524288, `o_exp` = −254.
  - Block 2: 8 beats of −65024, scales 254/254 → `o_acc` = −520192, `o_exp` = 254.
- NaN and scale sampling: beat 0 scales 255/127, later beats 127/127, `i_dp` alternating +5/−3 → `o_nan` = 1, `o_acc` = 8, `o_exp` = 128.
- Backpressure:
  - Result held with `i_ready` = 0 for 3 cycles while the next block's beats are offered. `o_ready` = 0 during the hold, and outputs stay stable.
  - `i_ready` = 1 → drain, and the next block proceeds. Its sum matches the reference and no beats are lost.
- Reset mid-block: 5 beats of +1000, then pulse `i_rst_n` low asynchronously between edges. All outputs go to 0 at once. A fresh 8-beat block of +1 → `o_acc` = 8.
- `n_beats` = 1 with random `i_dp` and scales every cycle, random `i_ready` → every accepted beat produces `o_acc` = `i_dp` with that cycle's scales. The scoreboard matches in order.

Source files
------------

// File: rtl/dot_acc_mx.sv
// Block accumulator behind the integer dot-product unit. It sums n_beats partial products into one
// MX block result, attaches the combined E8M0 exponent, and holds the result until it is taken.
module dot_acc_mx #(
    parameter int unsigned bit_width = 8,
    parameter int unsigned k         = 4,
    parameter int unsigned n_beats   = 8,
    parameter int unsigned in_width  = 2 * bit_width + $clog2(k),
    parameter int unsigned acc_width = in_width + $clog2(n_beats)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [in_width-1:0]  i_dp,
    input  logic [7:0]           i_scale_a,
    input  logic [7:0]           i_scale_b,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [acc_width-1:0] o_acc,
    output logic [9:0]           o_exp,
    output logic                 o_nan
);

    localparam int unsigned cnt_width = (n_beats > 1) ? $clog2(n_beats) : 1;
    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(n_beats - 1);

    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [acc_width-1:0] acc_q, acc_d;
    logic [7:0]           sa_q, sa_d, sb_q, sb_d;
    logic                 valid_q, valid_d;
    logic [acc_width-1:0] res_acc_q, res_acc_d;
    logic [9:0]           res_exp_q, res_exp_d;
    logic                 res_nan_q, res_nan_d;

    logic                 accept, first, last;
    logic [acc_width-1:0] dp_ext, sum;
    logic [7:0]           sa_eff, sb_eff;

    assign o_ready = !valid_q || i_ready;
    assign o_valid = valid_q;
    assign o_acc   = res_acc_q;
    assign o_exp   = res_exp_q;
    assign o_nan   = res_nan_q;

    always_comb begin
        accept = i_valid && o_ready;
        first  = (cnt_q == '0);
        last   = (cnt_q == last_cnt);
        dp_ext = acc_width'($signed(i_dp));
        // Beat 0 starts a fresh sum, so the stale accumulator never leaks into the next block.
        sum    = (first ? '0 : acc_q) + dp_ext;
        // Beat 0 scales come straight from the inputs; that also covers n_beats == 1.
        sa_eff = first ? i_scale_a : sa_q;
        sb_eff = first ? i_scale_b : sb_q;

        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        valid_d   = valid_q;
        res_acc_d = res_acc_q;
        res_exp_d = res_exp_q;
        res_nan_d = res_nan_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            acc_d = sum;
            if (first) begin
                sa_d = i_scale_a;
                sb_d = i_scale_b;
            end
            if (last) begin
                cnt_d     = '0;
                valid_d   = 1'b1;
                res_acc_d = sum;
                res_exp_d = {2'b00, sa_eff} + {2'b00, sb_eff} - 10'd254;
                res_nan_d = (sa_eff == 8'hFF) || (sb_eff == 8'hFF);
            end else begin
                cnt_d = cnt_q + cnt_width'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            valid_q   <= 1'b0;
            res_acc_q <= '0;
            res_exp_q <= '0;
            res_nan_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            valid_q   <= valid_d;
            res_acc_q <= res_acc_d;
            res_exp_q <= res_exp_d;
            res_nan_q <= res_nan_d;
        end
    end

endmodule

// File: tb/tb_dot_acc_mx.sv
// Scoreboard bench for dot_acc_mx: one instance with 8-beat blocks and one with 1-beat blocks.
module tb_dot_acc_mx;

    localparam int IW  = 18;
    localparam int AW  = 21;
    localparam int AW2 = 18;

    typedef struct {
        int acc;
        int ex;
        bit nan;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          valid, ir, o_ready, o_valid, o_nan;
    logic [IW-1:0] dp;
    logic [7:0]    sa, sb;
    logic [AW-1:0] o_acc;
    logic [9:0]    o_exp;

    logic           valid2, ir2, o_ready2, o_valid2, o_nan2;
    logic [IW-1:0]  dp2;
    logic [7:0]     sa2, sb2;
    logic [AW2-1:0] o_acc2;
    logic [9:0]     o_exp2;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dot_acc_mx u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_dp      (dp),
        .i_scale_a (sa),
        .i_scale_b (sb),
        .i_valid   (valid),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .i_ready   (ir),
        .o_acc     (o_acc),
        .o_exp     (o_exp),
        .o_nan     (o_nan)
    );

    dot_acc_mx #(.n_beats(1)) u_dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_dp      (dp2),
        .i_scale_a (sa2),
        .i_scale_b (sb2),
        .i_valid   (valid2),
        .o_ready   (o_ready2),
        .o_valid   (o_valid2),
        .i_ready   (ir2),
        .o_acc     (o_acc2),
        .o_exp     (o_exp2),
        .o_nan     (o_nan2)
    );

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitors: a result leaves when valid and ready are both high at the next rising edge.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && o_valid && ir) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8 unexpected result: got acc %0d expected none",
                         int'($signed(o_acc)));
            end else begin
                e = q1.pop_front();
                check_int("dut8 acc", int'($signed(o_acc)), e.acc);
                check_int("dut8 exp", int'($signed(o_exp)), e.ex);
                check_int("dut8 nan", int'(o_nan), int'(e.nan));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst_n && o_valid2 && ir2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected result: got acc %0d expected none",
                         int'($signed(o_acc2)));
            end else begin
                e = q2.pop_front();
                check_int("dut1 acc", int'($signed(o_acc2)), e.acc);
                check_int("dut1 exp", int'($signed(o_exp2)), e.ex);
                check_int("dut1 nan", int'(o_nan2), int'(e.nan));
            end
        end
    end

    task automatic send_beat(input int d, input int a, input int b);
        bit ok;
        valid = 1'b1;
        dp    = IW'(d);
        sa    = 8'(a);
        sb    = 8'(b);
        ok    = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = o_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat accept timeout: got o_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int d[8], input int a0, input int b0,
                              input int al, input int bl, input bit idle_after);
        exp_t e;
        e.acc = 0;
        foreach (d[i]) e.acc += d[i];
        e.ex  = a0 + b0 - 254;
        e.nan = (a0 == 255) || (b0 == 255);
        q1.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) send_beat(d[i], a0, b0);
            else        send_beat(d[i], al, bl);
        end
        if (idle_after) valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v[8];
        valid = 0; dp = '0; sa = '0; sb = '0; ir = 1'b1;
        valid2 = 0; dp2 = '0; sa2 = '0; sb2 = '0; ir2 = 1'b1;

        #1;
        check_int("reset o_valid", int'(o_valid), 0);
        check_int("reset o_acc", int'(o_acc), 0);
        check_int("reset o_exp", int'(o_exp), 0);
        check_int("reset o_nan", int'(o_nan), 0);
        check_int("reset o_ready", int'(o_ready), 1);
        check_int("reset o_valid2", int'(o_valid2), 0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Neutral exponent, plain sum
        v = '{8{100}};
        send_block(v, 127, 127, 127, 127, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_int("t1 drained", q1.size(), 0);

        // Extremes, back to back
        v = '{8{65536}};
        send_block(v, 0, 0, 0, 0, 1'b0);
        v = '{8{-65024}};
        send_block(v, 254, 254, 254, 254, 1'b1);

        // NaN from beat-0 scale; later scales ignored
        v = '{5, -3, 5, -3, 5, -3, 5, -3};
        send_block(v, 255, 127, 127, 127, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_int("t3 drained", q1.size(), 0);

        // Backpressure: hold block A while block B's first beat is offered
        ir = 1'b0;
        v = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_block(v, 130, 120, 130, 120, 1'b0);
        valid = 1'b1; dp = IW'(10); sa = 8'd127; sb = 8'd128;
        repeat (3) begin
            @(negedge clk);
            check_int("hold o_ready", int'(o_ready), 0);
            check_int("hold o_valid", int'(o_valid), 1);
            check_int("hold o_acc", int'($signed(o_acc)), 36);
            check_int("hold o_exp", int'($signed(o_exp)), -4);
        end
        @(posedge clk);
        #1;
        ir = 1'b1;
        v = '{10, 20, 30, 40, 50, 60, 70, 80};
        send_block(v, 127, 128, 3, 3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_int("t4 drained", q1.size(), 0);

        // Reset mid-block discards the partial sum and the held result
        for (int i = 0; i < 5; i++) send_beat(1000, 127, 127);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("midrst o_valid", int'(o_valid), 0);
        check_int("midrst o_acc", int'(o_acc), 0);
        check_int("midrst o_exp", int'(o_exp), 0);
        check_int("midrst o_nan", int'(o_nan), 0);
        check_int("midrst o_ready", int'(o_ready), 1);
        valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{8{1}};
        send_block(v, 127, 127, 127, 127, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_int("t5 drained", q1.size(), 0);

        // n_beats = 1: every accepted beat is a block
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            valid2 = ($urandom_range(0, 3) != 0);
            dp2    = IW'($urandom);
            sa2    = (i % 7 == 0)  ? 8'hFF : 8'($urandom_range(0, 254));
            sb2    = (i % 11 == 3) ? 8'hFF : 8'($urandom_range(0, 254));
            ir2    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (valid2 && o_ready2) begin
                exp_t e;
                e.acc = int'($signed(dp2));
                e.ex  = int'(sa2) + int'(sb2) - 254;
                e.nan = (sa2 == 8'hFF) || (sb2 == 8'hFF);
                q2.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        ir2    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_int("dut1 drained", q2.size(), 0);
        check_int("dut8 final drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
